// File: rtl/mem_access.sv
// Memory-access pipeline stage: forwards ALU results, runs aligned loads/stores
// through a single-outstanding data-memory handshake, and flags misaligned accesses.
module mem_access (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_MEM_valid,
    input  logic        i_MEM_regWe,
    input  logic [4:0]  i_MEM_WRA,
    input  logic [31:0] i_MEM_aluRst,
    input  logic [31:0] i_MEM_storeD,
    input  logic        i_MEM_memRe,
    input  logic        i_MEM_memWe,
    input  logic [1:0]  i_MEM_size,
    input  logic        i_MEM_unsigned,
    output logic        o_MEM_stall,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_be,
    input  logic        i_dmem_ready,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_MEM_regWe,
    output logic [4:0]  o_MEM_WRA,
    output logic [31:0] o_MEM_WRD,
    output logic        o_MEM_misalign
);

    typedef enum logic {StIdle, StAccess} state_t;

    state_t      r_state, w_state_next;
    logic        w_mem_op, w_misalign, w_in_idle, w_in_access, w_accept, w_done, w_stall;

    logic        r_we, r_regWe, r_unsigned;
    logic [4:0]  r_WRA;
    logic [31:0] r_addr, r_storeD;
    logic [1:0]  r_size;

    logic        r_out_regWe, r_out_misalign;
    logic [4:0]  r_out_WRA;
    logic [31:0] r_out_WRD;

    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_load;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_mem_op    = i_MEM_memRe | i_MEM_memWe;
    assign w_in_idle   = (r_state == StIdle);
    assign w_in_access = (r_state == StAccess);

    always_comb begin
        w_misalign = 1'b0;
        case (i_MEM_size)
            2'b00:   w_misalign = 1'b0;
            2'b01:   w_misalign = i_MEM_aluRst[0];
            default: w_misalign = |i_MEM_aluRst[1:0];
        endcase
    end

    assign w_accept = w_in_idle & i_MEM_valid & w_mem_op & ~w_misalign;
    assign w_done   = w_in_access & i_dmem_ready;
    assign w_stall  = w_accept | (w_in_access & ~i_dmem_ready);
    // Stall is forced low while reset is asserted, like every other o_MEM_* output.
    assign o_MEM_stall = rstn & w_stall;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:   if (w_accept) w_state_next = StAccess;
            StAccess: if (i_dmem_ready) w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_we       <= 1'b0;
            r_regWe    <= 1'b0;
            r_unsigned <= 1'b0;
            r_WRA      <= 5'd0;
            r_addr     <= 32'd0;
            r_storeD   <= 32'd0;
            r_size     <= 2'b00;
        end else if (w_accept) begin
            r_we       <= i_MEM_memWe;
            r_regWe    <= i_MEM_regWe;
            r_unsigned <= i_MEM_unsigned;
            r_WRA      <= i_MEM_WRA;
            r_addr     <= i_MEM_aluRst;
            r_storeD   <= i_MEM_storeD;
            r_size     <= i_MEM_size;
        end
    end

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = r_storeD;
        case (r_size)
            2'b00: begin
                w_be    = 4'b0001 << r_addr[1:0];
                w_wdata = {4{r_storeD[7:0]}};
            end
            2'b01: begin
                w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{r_storeD[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = r_storeD;
            end
        endcase
    end

    always_comb begin
        w_byte = i_dmem_rdata[7:0];
        case (r_addr[1:0])
            2'b00:   w_byte = i_dmem_rdata[7:0];
            2'b01:   w_byte = i_dmem_rdata[15:8];
            2'b10:   w_byte = i_dmem_rdata[23:16];
            default: w_byte = i_dmem_rdata[31:24];
        endcase
        w_half = r_addr[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
        case (r_size)
            2'b00:   w_load = r_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load = r_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load = i_dmem_rdata;
        endcase
    end

    assign o_dmem_req   = w_in_access;
    assign o_dmem_we    = w_in_access & r_we;
    assign o_dmem_be    = w_in_access ? w_be : 4'b0000;
    assign o_dmem_addr  = {r_addr[31:2], 2'b00};
    assign o_dmem_wdata = w_wdata;

    // Stores and misaligned ops leave WRA/WRD untouched; only results that carry data update them.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out_regWe    <= 1'b0;
            r_out_misalign <= 1'b0;
            r_out_WRA      <= 5'd0;
            r_out_WRD      <= 32'd0;
        end else begin
            r_out_regWe    <= 1'b0;
            r_out_misalign <= 1'b0;
            if (w_in_idle && i_MEM_valid) begin
                if (!w_mem_op) begin
                    r_out_regWe <= i_MEM_regWe & (|i_MEM_WRA);
                    r_out_WRA   <= i_MEM_WRA;
                    r_out_WRD   <= i_MEM_aluRst;
                end else if (w_misalign) begin
                    r_out_misalign <= 1'b1;
                end
            end else if (w_done && !r_we) begin
                r_out_regWe <= r_regWe & (|r_WRA);
                r_out_WRA   <= r_WRA;
                r_out_WRD   <= w_load;
            end
        end
    end

    assign o_MEM_regWe    = r_out_regWe;
    assign o_MEM_WRA      = r_out_WRA;
    assign o_MEM_WRD      = r_out_WRD;
    assign o_MEM_misalign = r_out_misalign;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios plus random instruction
// mix checked against a transaction-level model of the stage.
module tb_mem_access;

    logic        clk, rstn;
    logic        i_MEM_valid, i_MEM_regWe, i_MEM_memRe, i_MEM_memWe, i_MEM_unsigned;
    logic [4:0]  i_MEM_WRA;
    logic [31:0] i_MEM_aluRst, i_MEM_storeD;
    logic [1:0]  i_MEM_size;
    logic        o_MEM_stall, o_dmem_req, o_dmem_we;
    logic [31:0] o_dmem_addr, o_dmem_wdata;
    logic [3:0]  o_dmem_be;
    logic        i_dmem_ready;
    logic [31:0] i_dmem_rdata;
    logic        o_MEM_regWe, o_MEM_misalign;
    logic [4:0]  o_MEM_WRA;
    logic [31:0] o_MEM_WRD;

    mem_access dut (
        .clk            (clk),
        .rstn           (rstn),
        .i_MEM_valid    (i_MEM_valid),
        .i_MEM_regWe    (i_MEM_regWe),
        .i_MEM_WRA      (i_MEM_WRA),
        .i_MEM_aluRst   (i_MEM_aluRst),
        .i_MEM_storeD   (i_MEM_storeD),
        .i_MEM_memRe    (i_MEM_memRe),
        .i_MEM_memWe    (i_MEM_memWe),
        .i_MEM_size     (i_MEM_size),
        .i_MEM_unsigned (i_MEM_unsigned),
        .o_MEM_stall    (o_MEM_stall),
        .o_dmem_req     (o_dmem_req),
        .o_dmem_we      (o_dmem_we),
        .o_dmem_addr    (o_dmem_addr),
        .o_dmem_wdata   (o_dmem_wdata),
        .o_dmem_be      (o_dmem_be),
        .i_dmem_ready   (i_dmem_ready),
        .i_dmem_rdata   (i_dmem_rdata),
        .o_MEM_regWe    (o_MEM_regWe),
        .o_MEM_WRA      (o_MEM_WRA),
        .o_MEM_WRD      (o_MEM_WRD),
        .o_MEM_misalign (o_MEM_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Expected registered outputs now, and what the next edge will produce.
    logic        m_regWe, m_mis, m_known;
    logic [4:0]  m_WRA;
    logic [31:0] m_WRD;
    logic        p_regWe, p_mis, p_upd;
    logic [4:0]  p_WRA;
    logic [31:0] p_WRD;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("regWe", 32'(o_MEM_regWe), 32'(m_regWe));
        chk("misalign", 32'(o_MEM_misalign), 32'(m_mis));
        if (m_known) begin
            chk("WRA", 32'(o_MEM_WRA), 32'(m_WRA));
            chk("WRD", o_MEM_WRD, m_WRD);
        end
    endtask

    task automatic clock_edge();
        @(posedge clk);
        #1;
        m_regWe = p_regWe;
        m_mis   = p_mis;
        if (p_upd) begin
            m_WRA   = p_WRA;
            m_WRD   = p_WRD;
            m_known = 1'b1;
        end
        p_regWe = 1'b0;
        p_mis   = 1'b0;
        p_upd   = 1'b0;
    endtask

    function automatic int unsigned f_bytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [3:0] f_be(input logic [31:0] addr, input logic [1:0] size);
        logic [3:0] be;
        int unsigned n, off;
        n  = f_bytes(size);
        off = int'(addr % 4);
        for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + n);
        return be;
    endfunction

    function automatic logic [31:0] f_wdata(input logic [31:0] d, input logic [1:0] size);
        logic [31:0] w;
        int unsigned n;
        n = f_bytes(size);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] f_load(input logic [31:0] addr, input logic [1:0] size,
                                           input logic uns, input logic [31:0] rdata);
        longint unsigned v, mask;
        int unsigned n, off;
        n    = f_bytes(size);
        off  = int'(addr % 4);
        mask = (64'd1 << (8 * n)) - 1;
        v    = (64'(rdata) >> (8 * off)) & mask;
        if (!uns && ((v >> (8 * n - 1)) & 1) == 1) v = v | ~mask;
        return v[31:0];
    endfunction

    task automatic drive_junk();
        i_MEM_valid    = 1'($urandom);
        i_MEM_regWe    = 1'($urandom);
        i_MEM_WRA      = 5'($urandom);
        i_MEM_aluRst   = $urandom;
        i_MEM_storeD   = $urandom;
        i_MEM_memRe    = 1'($urandom);
        i_MEM_memWe    = 1'($urandom);
        i_MEM_size     = 2'($urandom);
        i_MEM_unsigned = 1'($urandom);
    endtask

    task automatic idle();
        drive_junk();
        i_MEM_valid  = 1'b0;
        i_dmem_ready = 1'($urandom);
        i_dmem_rdata = $urandom;
        @(negedge clk);
        check_outputs();
        chk("idle_stall", 32'(o_MEM_stall), 32'd0);
        chk("idle_req", 32'(o_dmem_req), 32'd0);
        chk("idle_be", 32'(o_dmem_be), 32'd0);
        clock_edge();
    endtask

    task automatic run_instr(input logic regWe, input logic [4:0] wra, input logic [31:0] alu,
                             input logic [31:0] sd, input logic re, input logic we,
                             input logic [1:0] size, input logic uns, input int delay,
                             input logic [31:0] rdata);
        logic mem, mis;
        mem = re | we;
        mis = (alu % f_bytes(size)) != 0;
        i_MEM_valid = 1'b1;  i_MEM_regWe = regWe; i_MEM_WRA = wra; i_MEM_aluRst = alu;
        i_MEM_storeD = sd;   i_MEM_memRe = re;    i_MEM_memWe = we; i_MEM_size = size;
        i_MEM_unsigned = uns;
        i_dmem_ready = 1'($urandom);
        i_dmem_rdata = $urandom;
        @(negedge clk);
        check_outputs();
        chk("accept_stall", 32'(o_MEM_stall), 32'(mem && !mis));
        chk("accept_req", 32'(o_dmem_req), 32'd0);
        if (!mem) begin
            p_regWe = regWe && (wra != 0);
            p_upd = 1'b1; p_WRA = wra; p_WRD = alu;
            clock_edge();
        end else if (mis) begin
            p_mis = 1'b1;
            clock_edge();
        end else begin
            clock_edge();
            for (int k = 0; k <= delay; k++) begin
                drive_junk();
                i_dmem_ready = (k == delay);
                i_dmem_rdata = (k == delay) ? rdata : $urandom;
                @(negedge clk);
                check_outputs();
                chk("acc_req", 32'(o_dmem_req), 32'd1);
                chk("acc_we", 32'(o_dmem_we), 32'(we));
                chk("acc_addr", o_dmem_addr, alu & ~32'h3);
                chk("acc_be", 32'(o_dmem_be), 32'(f_be(alu, size)));
                if (we) chk("acc_wdata", o_dmem_wdata, f_wdata(sd, size));
                chk("acc_stall", 32'(o_MEM_stall), 32'(k != delay));
                if (k == delay && !we) begin
                    p_regWe = regWe && (wra != 0);
                    p_upd = 1'b1; p_WRA = wra; p_WRD = f_load(alu, size, uns, rdata);
                end
                clock_edge();
            end
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        int          kind;
        m_regWe = 0; m_mis = 0; m_known = 1; m_WRA = 0; m_WRD = 0;
        p_regWe = 0; p_mis = 0; p_upd = 0; p_WRA = 0; p_WRD = 0;
        rstn = 1'b0;
        drive_junk();
        i_dmem_ready = 1'b0;
        i_dmem_rdata = 32'd0;
        #12;
        check_outputs();
        chk("rst_stall", 32'(o_MEM_stall), 32'd0);
        chk("rst_req", 32'(o_dmem_req), 32'd0);
        chk("rst_be", 32'(o_dmem_be), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        idle();

        // ALU op, signed byte load, delayed half store, misaligned word load
        run_instr(1, 5'd5, 32'h1234, 32'h0, 0, 0, 2'b10, 0, 0, 32'h0);
        run_instr(1, 5'd7, 32'h1003, 32'h0, 1, 0, 2'b00, 0, 0, 32'h80FF_FF00);
        run_instr(1, 5'd8, 32'h2002, 32'hABCD, 0, 1, 2'b01, 0, 3, 32'h0);
        run_instr(1, 5'd9, 32'h3001, 32'h0, 1, 0, 2'b10, 0, 0, 32'h0);
        idle();

        // back-to-back loads, one targeting x0
        run_instr(1, 5'd1, 32'h100, 32'h0, 1, 0, 2'b10, 0, 0, 32'hCAFE_F00D);
        run_instr(1, 5'd0, 32'h106, 32'h0, 1, 0, 2'b01, 0, 0, 32'h8001_2345);
        run_instr(1, 5'd2, 32'h106, 32'h0, 1, 0, 2'b01, 1, 0, 32'h8001_2345);
        run_instr(1, 5'd3, 32'h105, 32'h0, 1, 0, 2'b00, 0, 0, 32'h0000_7F00);
        idle();

        for (int i = 0; i < 150; i++) begin
            kind = int'($urandom_range(0, 3));
            sz   = 2'($urandom);
            a    = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~(32'(f_bytes(sz)) - 1);
            if (kind == 3) idle();
            else run_instr(1'($urandom), 5'($urandom), a, $urandom, kind == 1, kind == 2,
                           sz, 1'($urandom), int'($urandom_range(0, 3)), $urandom);
        end
        idle();

        // reset in the middle of an access
        run_instr(1, 5'd4, 32'h4000, 32'h0, 0, 0, 2'b10, 0, 0, 32'h0);
        i_MEM_valid = 1; i_MEM_regWe = 1; i_MEM_WRA = 5'd6; i_MEM_aluRst = 32'h4004;
        i_MEM_memRe = 1; i_MEM_memWe = 0; i_MEM_size = 2'b10; i_dmem_ready = 0;
        @(negedge clk);
        check_outputs();
        clock_edge();
        @(negedge clk);
        chk("pre_rst_req", 32'(o_dmem_req), 32'd1);
        #2;
        rstn = 1'b0;
        i_MEM_valid = 1'b0;
        #1;
        m_regWe = 0; m_mis = 0; m_WRA = 0; m_WRD = 0; m_known = 1;
        chk("arst_req", 32'(o_dmem_req), 32'd0);
        chk("arst_we", 32'(o_dmem_we), 32'd0);
        chk("arst_be", 32'(o_dmem_be), 32'd0);
        chk("arst_stall", 32'(o_MEM_stall), 32'd0);
        check_outputs();
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with the ports listed below.
- clk  in  1  rising-edge clock
- rstn  in  1  asynchronous active-low reset
- i_MEM_valid  in  1  instruction present this cycle
- i_MEM_regWe  in  1  instruction writes a register
- i_MEM_WRA  in  5  destination register
- i_MEM_aluRst  in  32  ALU result, or effective address for memory ops
- i_MEM_storeD  in  32  store data
- i_MEM_memRe  in  1  load
- i_MEM_memWe  in  1  store; takes priority over memRe
- i_MEM_size  in  2  00 byte, 01 half, 10/11 word
- i_MEM_unsigned  in  1  zero-extend loads
- o_MEM_stall  out  1  upstream holds its instruction
- o_dmem_req, o_dmem_we  out  1 each  data-memory request and write
- o_dmem_addr  out  32  word-aligned address, {aluRst[31:2],2'b00}
- o_dmem_wdata  out  32  lane-replicated store data
- o_dmem_be  out  4  byte enables
- i_dmem_ready  in  1  request completes this cycle
- i_dmem_rdata  in  32  read word, valid when ready
- o_MEM_regWe, o_MEM_WRA, o_MEM_WRD  out  1/5/32  registered results, feeding the writeback stage
- o_MEM_misalign  out  1  one-cycle misalignment flag

Function
REQ-002 The FSM SHALL have two states: IDLE and ACCESS.
REQ-003 A memory op is memRe|memWe. It is misaligned if half with aluRst[0]=1, or word with aluRst[1:0]!=0.
REQ-004 IDLE, valid, non-memory op: SHALL register regWe/WRA/WRD=aluRst with 1-cycle latency; stall=0; stay IDLE.
REQ-005 IDLE, valid, misaligned memory op: no request; SHALL pulse o_MEM_misalign=1 and o_MEM_regWe=0 next cycle; stall=0.
REQ-006 IDLE, valid, aligned memory op: SHALL hold stall=1 combinationally, latch all inputs, and enter ACCESS.
REQ-007 In ACCESS, o_dmem_req SHALL be 1 and the dmem outputs SHALL come only from the latched copy; inputs are ignored.
REQ-008 In ACCESS, stall SHALL equal !i_dmem_ready; upstream advances at the edge where stall=0.
REQ-009 On ACCESS with ready=1: SHALL register the result next cycle and return to IDLE. Minimum load/store occupancy is 2 cycles: accept N, req N+1, result N+2.
REQ-010 Byte enables: byte SHALL be 1<<addr[1:0]; half SHALL be 0011 (addr[1]=0) or 1100; word SHALL be 1111.
REQ-011 wdata SHALL replicate storeD[7:0] ×4 for byte and storeD[15:0] ×2 for half; word is passed as is.
REQ-012 Load data SHALL select the lane by addr[1:0] (byte) or addr[1] (half), then sign- or zero-extend per i_MEM_unsigned.
REQ-013 Stores SHALL force o_MEM_regWe=0. Loads SHALL output regWe=i_MEM_regWe and WRD=extended data.
REQ-014 WRA=0 SHALL always force o_MEM_regWe=0.
REQ-015 o_MEM_regWe and o_MEM_misalign SHALL be single-cycle pulses per instruction, and 0 when no instruction completes.
REQ-016 o_MEM_WRA and o_MEM_WRD SHALL hold their last values when no instruction completes.
REQ-017 When valid=0 in IDLE: stall=0, outputs pulse low, and no request is issued.
REQ-018 ready while in IDLE SHALL be ignored.

Reset
REQ-019 rstn=0 SHALL immediately force IDLE, o_dmem_req=0, o_dmem_we=0, be=0, and all o_MEM_* outputs 0, including mid-ACCESS.
REQ-020 The request SHALL be abandoned on reset, and no result is produced for it after release.

Verification
REQ-021 ALU op: valid, regWe=1, WRA=5, aluRst=0x1234 -> next cycle regWe=1, WRA=5, WRD=0x1234; stall always 0.
REQ-022 Signed load byte at 0x1003, rdata=0x80FFFF00, ready on first req cycle -> req=1 one cycle, be=1000, WRD=0xFFFFFF80 two cycles after accept.
REQ-023 Store half at 0x2002, storeD=0xABCD, ready delayed 3 cycles -> be=1100, wdata=0xABCDABCD, stall 1 for 4 cycles, regWe=0.
REQ-024 Load word at 0x3001 -> no req; misalign pulse 1 cycle; regWe=0.
REQ-025 rstn low during ACCESS -> req drops asynchronously; after release IDLE, outputs 0, and no result is produced.
REQ-026 Back-to-back loads with ready=1 -> one completion every 2 cycles, results in order; WRA=0 load gives regWe=0.
